lsu_mem_responder: RTL and testbench

- Memory-side responder for the load/store units of the PE rows.
- Accepts per-row read/write requests with an address and write data, arbitrates round-robin, and performs one access per cycle on a single-port word memory.
- Returns read data and grant/valid strobes to each row.
- Sits on the CBG side, one instance serving all rows of the array.

---
 rtl/lsu_mem_responder.sv | 141 ++++++++++++++
 tb/tb_lsu_mem_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_responder.sv
// Memory-side responder shared by all PE-row load/store units.
// Round-robin arbitration picks one row per cycle and performs one access on a
// single-port word memory. Each granted access returns a one-cycle grant
// strobe; reads also return data on the row's rdata slice.
// Optional feature: define LSU_MEM_STATS_EN to add the rd_count/wr_count
// grant counters.
module lsu_mem_responder #(
    parameter int unsigned NUM_ROWS = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned DEPTH    = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_ROWS-1:0]          r_req,
    input  logic [NUM_ROWS-1:0]          w_req,
    input  logic [NUM_ROWS*ADDR_W-1:0]   addr_bus,
    input  logic [NUM_ROWS*DATA_W-1:0]   wdata_bus,
    output logic [NUM_ROWS-1:0]          r_grant,
    output logic [NUM_ROWS-1:0]          w_grant,
    output logic [NUM_ROWS*DATA_W-1:0]   rdata_bus,
    output logic                         err,
    output logic                         busy
`ifdef LSU_MEM_STATS_EN
    ,
    output logic [31:0]                  rd_count,
    output logic [31:0]                  wr_count
`endif
);

    localparam int unsigned PTR_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0]          mem [DEPTH];

    logic [PTR_W-1:0]           ptr_q, ptr_d;
    logic [NUM_ROWS-1:0]        mask_q;
    logic [NUM_ROWS-1:0]        r_grant_q, w_grant_q;
    logic [NUM_ROWS*DATA_W-1:0] rdata_q;
    logic                       err_q;

    logic [NUM_ROWS-1:0]        elig;
    logic                       found;
    logic [PTR_W-1:0]           sel;
    logic [PTR_W-1:0]           cand;
    logic [ADDR_W-1:0]          sel_addr;
    logic [DATA_W-1:0]          sel_wdata;
    logic                       is_write;
    logic                       in_range;
    logic [IDX_W-1:0]           mem_idx;

    // The row granted last edge is masked while its grant is visible, so a
    // request it has not yet withdrawn cannot win a second time.
    assign elig = (r_req | w_req) & ~mask_q;
    assign busy = |elig;

    // Round-robin search starting at the pointer, plus decode of the winner.
    always_comb begin
        found = 1'b0;
        sel   = '0;
        cand  = '0;
        for (int unsigned o = 0; o < NUM_ROWS; o++) begin
            cand = PTR_W'((32'(ptr_q) + o) % NUM_ROWS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end
        ptr_d     = PTR_W'((32'(sel) + 1) % NUM_ROWS);
        sel_addr  = addr_bus[32'(sel)*ADDR_W +: ADDR_W];
        sel_wdata = wdata_bus[32'(sel)*DATA_W +: DATA_W];
        // Write wins when both are requested; the read competes again later.
        is_write  = w_req[sel];
        in_range  = 32'(sel_addr) < DEPTH;
        mem_idx   = IDX_W'(sel_addr);
    end

    // Arbitration state, grant strobes, error pulse and per-row read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q     <= '0;
            mask_q    <= '0;
            r_grant_q <= '0;
            w_grant_q <= '0;
            err_q     <= 1'b0;
            rdata_q   <= '0;
        end else begin
            r_grant_q <= '0;
            w_grant_q <= '0;
            mask_q    <= '0;
            err_q     <= 1'b0;
            if (found) begin
                ptr_q       <= ptr_d;
                mask_q[sel] <= 1'b1;
                err_q       <= !in_range;
                if (is_write) begin
                    w_grant_q[sel] <= 1'b1;
                end else begin
                    r_grant_q[sel] <= 1'b1;
                    rdata_q[32'(sel)*DATA_W +: DATA_W] <= in_range ? mem[mem_idx] : '0;
                end
            end
        end
    end

    // Memory array; contents survive reset and out-of-range writes are dropped.
    always_ff @(posedge clk) begin
        if (!rst && found && is_write && in_range) begin
            mem[mem_idx] <= sel_wdata;
        end
    end

    assign r_grant   = r_grant_q;
    assign w_grant   = w_grant_q;
    assign rdata_bus = rdata_q;
    assign err       = err_q;

`ifdef LSU_MEM_STATS_EN
    logic [31:0] rd_count_q, wr_count_q;

    // Count every issued grant, out-of-range ones included; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else if (found) begin
            if (is_write) begin
                wr_count_q <= wr_count_q + 32'd1;
            end else begin
                rd_count_q <= rd_count_q + 32'd1;
            end
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_lsu_mem_responder.sv
// Scoreboard bench for lsu_mem_responder: a transaction-level model predicts
// each grant when stimulus is driven; a monitor compares every DUT grant.
module tb_lsu_mem_responder;

    localparam int N     = 4;
    localparam int AW    = 11;
    localparam int DW    = 32;
    localparam int DEPTH = 1024;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     r_req = '0;
    logic [N-1:0]     w_req = '0;
    logic [N*AW-1:0]  addr_bus = '0;
    logic [N*DW-1:0]  wdata_bus = '0;
    logic [N-1:0]     r_grant, w_grant;
    logic [N*DW-1:0]  rdata_bus;
    logic             err, busy;
`ifdef LSU_MEM_STATS_EN
    logic [31:0]      rd_count, wr_count;
`endif

    lsu_mem_responder #(
        .NUM_ROWS (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .r_req     (r_req),
        .w_req     (w_req),
        .addr_bus  (addr_bus),
        .wdata_bus (wdata_bus),
        .r_grant   (r_grant),
        .w_grant   (w_grant),
        .rdata_bus (rdata_bus),
        .err       (err),
        .busy      (busy)
`ifdef LSU_MEM_STATS_EN
        ,
        .rd_count  (rd_count),
        .wr_count  (wr_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int           cyc;
        logic [N-1:0] rg;
        logic [N-1:0] wg;
        logic         err;
        logic [31:0]  data;
        bit           chk;
        int           row;
    } exp_t;

    // Requester state per row and the reference model.
    bit          rq_rd [N];
    bit          rq_wr [N];
    logic [AW-1:0] rq_addr [N];
    logic [31:0] rq_data [N];
    logic [31:0] mem_m [int];
    int          ptr_m = 0;
    int          last_row = -1;
    int          mode = 0;
    int          cyc = 0;
    int          rd_m = 0;
    int          wr_m = 0;
    exp_t        sb [$];

    int          n_pass = 0;
    int          n_total = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic set_req(input int row, input bit rd, input bit wr, input int addr,
                           input logic [31:0] data);
        rq_rd[row]   = rd;
        rq_wr[row]   = wr;
        rq_addr[row] = AW'(addr);
        rq_data[row] = data;
    endtask

    // New request for an idle row, according to the current stimulus mode.
    task automatic refill(input int i);
        int op;
        if (rq_rd[i] || rq_wr[i]) return;
        if (mode == 1) begin
            set_req(i, 1'b1, 1'b0, i, 32'h0);
        end else if (mode == 2 && $urandom_range(1) == 1) begin
            op = int'($urandom_range(2));
            if ($urandom_range(7) == 0) set_req(i, op != 1, op != 0, 1024 + int'($urandom_range(15)), $urandom);
            else set_req(i, op != 1, op != 0, int'($urandom_range(15)), $urandom);
        end
    endtask

    // One cycle of stimulus: drive inputs at the falling edge, predict the
    // outcome of the next rising edge, then let the requesters react.
    task automatic drive_cycle(input bit do_rst);
        exp_t e;
        int   k, j, a;
        bit   exp_busy;
        @(negedge clk);
        cyc++;
        rst = do_rst;
        for (int i = 0; i < N; i++) begin
            r_req[i] = rq_rd[i];
            w_req[i] = rq_wr[i];
            addr_bus[i*AW +: AW]  = rq_addr[i];
            wdata_bus[i*DW +: DW] = rq_data[i];
        end
        if (do_rst) begin
            ptr_m = 0;
            last_row = -1;
            rd_m = 0;
            wr_m = 0;
            #1;
            return;
        end
        k = -1;
        exp_busy = 1'b0;
        for (int o = 0; o < N; o++) begin
            j = (ptr_m + o) % N;
            if ((rq_rd[j] || rq_wr[j]) && j != last_row) begin
                exp_busy = 1'b1;
                if (k < 0) k = j;
            end
        end
        last_row = k;
        if (k >= 0) begin
            e.cyc = cyc;
            e.rg = '0;
            e.wg = '0;
            e.row = k;
            e.chk = 1'b0;
            e.data = '0;
            a = int'(rq_addr[k]);
            e.err = !(a < DEPTH);
            if (rq_wr[k]) begin
                e.wg[k] = 1'b1;
                if (a < DEPTH) mem_m[a] = rq_data[k];
                wr_m++;
                rq_wr[k] = 1'b0;
            end else begin
                e.rg[k] = 1'b1;
                rd_m++;
                rq_rd[k] = 1'b0;
                if (!(a < DEPTH)) begin
                    e.chk = 1'b1;
                end else if (mem_m.exists(a)) begin
                    e.chk = 1'b1;
                    e.data = mem_m[a];
                end
            end
            sb.push_back(e);
            ptr_m = (k + 1) % N;
        end
        for (int i = 0; i < N; i++) refill(i);
        #1;
        check("busy", 128'(busy), 128'(exp_busy));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0);
    endtask

    task automatic check_cleared(input string name);
        @(posedge clk);
        #1;
        check({name, "_strobes"}, 128'({r_grant, w_grant, err}), 128'(0));
        check({name, "_rdata"}, 128'(rdata_bus), 128'(0));
`ifdef LSU_MEM_STATS_EN
        check({name, "_counts"}, 128'({rd_count, wr_count}), 128'(0));
`endif
    endtask

    // Monitor: every grant the DUT presents must match the next prediction.
    initial begin
        exp_t         e;
        logic [N-1:0] prev_g;
        prev_g = '0;
        forever begin
            @(posedge clk);
            #1;
            if ((r_grant | w_grant) != '0) begin
                if (sb.size() == 0) begin
                    check("unexpected_grant", 128'({r_grant, w_grant}), 128'(0));
                end else begin
                    e = sb.pop_front();
                    check("grant", 128'({cyc, r_grant, w_grant, err}),
                          128'({e.cyc, e.rg, e.wg, e.err}));
                    if (e.chk) check("rdata", 128'(rdata_bus[e.row*DW +: DW]), 128'(e.data));
                end
                if (prev_g != '0) check("repeat_grant", 128'((r_grant | w_grant) & prev_g), 128'(0));
                prev_g = r_grant | w_grant;
            end else begin
                if (err) check("err_without_grant", 128'(err), 128'(0));
                prev_g = '0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, %0d of %0d checks passed", n_pass, n_total);
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < N; i++) set_req(i, 1'b0, 1'b0, 0, 32'h0);
        drive_cycle(1'b1);
        drive_cycle(1'b1);
        check_cleared("reset");

        // Write then read-after-write across rows.
        set_req(1, 1'b0, 1'b1, 5, 32'hDEADBEEF);
        drive_cycle(1'b0);
        set_req(2, 1'b1, 1'b0, 5, 32'h0);
        run(4);

        // Simultaneous read and write from one row: write first, read later.
        set_req(0, 1'b1, 1'b1, 7, 32'h12);
        run(4);

        // Out-of-range read and write; the dropped write must not alias addr 6.
        set_req(1, 1'b0, 1'b1, 6, 32'hA5A5A5A5);
        run(2);
        set_req(3, 1'b1, 1'b0, 1030, 32'h0);
        set_req(2, 1'b0, 1'b1, 1030, 32'hFFFFFFFF);
        drive_cycle(1'b0);
        set_req(0, 1'b1, 1'b0, 6, 32'h0);
        run(4);

        // All rows hold reads from reset: strict rotation 0,1,2,3,0...
        drive_cycle(1'b1);
        check_cleared("reset2");
        mode = 1;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 1'b0, i, 32'h0);
        run(9);
        // Reset on an edge that would have issued a grant.
        drive_cycle(1'b1);
        check_cleared("midreset");
        run(5);
        mode = 0;
        run(8);

        // Randomized traffic, then drain.
        mode = 2;
        run(300);
        mode = 0;
        run(12);
        run(3);
        check("scoreboard_empty", 128'(sb.size()), 128'(0));
`ifdef LSU_MEM_STATS_EN
        check("rd_count", 128'(rd_count), 128'(rd_m));
        check("wr_count", 128'(wr_count), 128'(wr_m));
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
